// File: rtl/datapath_rr_arbiter.sv
// Round-robin arbiter granting one requester at a time to a shared flop-feedback datapath stage.
// Optional macro DP_ARB_RECOVER_EN inserts a one-cycle RECOVER bubble between tenures.
module datapath_rr_arbiter #(
   parameter int NREQ = 4,
   parameter int HOLD = 4
) (
   input  logic                    tau2015_clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         last,
   output logic [NREQ-1:0]         gnt,
   output logic [$clog2(NREQ)-1:0] gnt_id,
   output logic                    dp_en,
   output logic                    busy
);

   localparam int IDW = $clog2(NREQ);
   localparam int BW  = $clog2(HOLD + 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
`ifdef DP_ARB_RECOVER_EN
      S_RECOVER = 2'd2,
`endif
      S_GRANT   = 2'd1
   } state_t;

   state_t          r_state;
   logic [NREQ-1:0] r_gnt;
   logic [IDW-1:0]  r_gnt_id;
   logic [IDW-1:0]  r_ptr;
   logic [BW-1:0]   r_beat;
   logic            r_busy;

   state_t          w_state_nxt;
   logic [NREQ-1:0] w_gnt_nxt;
   logic [IDW-1:0]  w_gnt_id_nxt;
   logic [IDW-1:0]  w_ptr_nxt;
   logic [BW-1:0]   w_beat_nxt;
   logic            w_dp_en;
   logic            w_end;
   logic [IDW-1:0]  w_ptr_inc;
   logic [IDW-1:0]  w_scan_ptr;
   logic            w_win_vld;
   logic [IDW-1:0]  w_win_id;
   logic [NREQ-1:0] w_win_onehot;

   assign w_dp_en   = |(r_gnt & req);
   assign w_ptr_inc = (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);

   // A tenure ends on an owner's last beat, at the HOLD limit, or when the owner drops its request.
   assign w_end = (r_state == S_GRANT) &&
                  ((w_dp_en && (last[r_gnt_id] || (r_beat == BW'(HOLD - 1)))) || !req[r_gnt_id]);

   // On a handover edge the scan must start from the pointer being written on that same edge.
   assign w_scan_ptr = (r_state == S_GRANT) ? w_ptr_inc : r_ptr;

   always_comb begin
      logic [IDW:0] v_idx;
      w_win_vld = 1'b0;
      w_win_id  = '0;
      // Scan downwards so the smallest offset from the pointer is the last one to write.
      for (int i = NREQ - 1; i >= 0; i--) begin
         v_idx = {1'b0, w_scan_ptr} + (IDW + 1)'(i);
         if (v_idx >= (IDW + 1)'(NREQ)) v_idx = v_idx - (IDW + 1)'(NREQ);
         if (req[v_idx[IDW-1:0]]) begin
            w_win_vld = 1'b1;
            w_win_id  = v_idx[IDW-1:0];
         end
      end
   end

   assign w_win_onehot = NREQ'(1) << w_win_id;

   // NOTE: every output of this block gets a default first, so no path can leave one unassigned and infer a latch.
   always_comb begin
      w_state_nxt  = r_state;
      w_gnt_nxt    = r_gnt;
      w_gnt_id_nxt = r_gnt_id;
      w_ptr_nxt    = r_ptr;
      w_beat_nxt   = r_beat;
      case (r_state)
         S_IDLE: begin
            if (w_win_vld) begin
               w_state_nxt  = S_GRANT;
               w_gnt_nxt    = w_win_onehot;
               w_gnt_id_nxt = w_win_id;
               w_beat_nxt   = '0;
            end
         end
         S_GRANT: begin
            if (w_end) begin
               w_ptr_nxt  = w_ptr_inc;
               w_beat_nxt = '0;
`ifdef DP_ARB_RECOVER_EN
               w_state_nxt = S_RECOVER;
               w_gnt_nxt   = '0;
`else
               if (w_win_vld) begin
                  w_gnt_nxt    = w_win_onehot;
                  w_gnt_id_nxt = w_win_id;
               end else begin
                  w_state_nxt = S_IDLE;
                  w_gnt_nxt   = '0;
               end
`endif
            end else if (w_dp_en) begin
               w_beat_nxt = r_beat + BW'(1);
            end
         end
`ifdef DP_ARB_RECOVER_EN
         S_RECOVER: begin
            if (w_win_vld) begin
               w_state_nxt  = S_GRANT;
               w_gnt_nxt    = w_win_onehot;
               w_gnt_id_nxt = w_win_id;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
`endif
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge tau2015_clk or posedge rst) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_gnt    <= '0;
         r_gnt_id <= '0;
         r_ptr    <= '0;
         r_beat   <= '0;
         r_busy   <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_gnt    <= w_gnt_nxt;
         r_gnt_id <= w_gnt_id_nxt;
         r_ptr    <= w_ptr_nxt;
         r_beat   <= w_beat_nxt;
         r_busy   <= (w_state_nxt != S_IDLE);
      end
   end

   assign gnt    = r_gnt;
   assign gnt_id = r_gnt_id;
   assign dp_en  = w_dp_en;
   assign busy   = r_busy;

endmodule

// File: tb/tb_datapath_rr_arbiter.sv
// Self-checking bench for datapath_rr_arbiter (NREQ=4, HOLD=4): a cycle table for round-robin
// rotation plus hand-written sequences for reset, early last, abandon and last-at-HOLD.
module tb_datapath_rr_arbiter;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic [3:0] last;
   logic [3:0] gnt;
   logic [1:0] gnt_id;
   logic       dp_en;
   logic       busy;

   int n_checks = 0;
   int n_fail   = 0;
   int step     = 0;

   typedef struct packed {
      logic [3:0] req;
      logic [3:0] last;
      logic [3:0] gnt;
      logic [1:0] id;
      logic       busy;
      logic       dp;
   } vec_t;

   vec_t tbl[$];

   datapath_rr_arbiter #(.NREQ(4), .HOLD(4)) dut (
      .tau2015_clk (clk),
      .rst         (rst),
      .req         (req),
      .last        (last),
      .gnt         (gnt),
      .gnt_id      (gnt_id),
      .dp_en       (dp_en),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, compare the outputs seen in that cycle, then move past the next edge.
   task automatic apply(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] eg, input logic [1:0] eid,
                        input logic eb, input logic ed);
      req  = r;
      last = l;
      #1;
      check($sformatf("%s#%0d.gnt", tag, step), 32'(gnt), 32'(eg));
      check($sformatf("%s#%0d.gnt_id", tag, step), 32'(gnt_id), 32'(eid));
      check($sformatf("%s#%0d.busy", tag, step), 32'(busy), 32'(eb));
      check($sformatf("%s#%0d.dp_en", tag, step), 32'(dp_en), 32'(ed));
      step++;
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] r, input logic [3:0] l, input logic [3:0] eg,
                      input logic [1:0] eid, input logic eb, input logic ed);
      vec_t v;
      v.req = r; v.last = l; v.gnt = eg; v.id = eid; v.busy = eb; v.dp = ed;
      tbl.push_back(v);
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = '0;
      last = '0;
      #2;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      int owners[5] = '{0, 1, 2, 3, 0};

      // Round-robin table: all four requesting, last never set, each owner gets HOLD=4 beats.
      add(4'b1111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < 4; b++)
            add(4'b1111, 4'b0000, 4'(1) << owners[k], 2'(owners[k]), 1'b1, 1'b1);
`ifdef DP_ARB_RECOVER_EN
         if (k < 4) add(4'b1111, 4'b0000, 4'b0000, 2'(owners[k]), 1'b1, 1'b0);
`endif
      end
`ifdef DP_ARB_RECOVER_EN
      add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
`else
      add(4'b0000, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0);
      add(4'b0000, 4'b0000, 4'b0000, 2'd1, 1'b0, 1'b0);
`endif

      // Reset state, then asynchronous reset in the middle of a grant.
      rst  = 1'b1;
      req  = '0;
      last = '0;
      #3;
      check("reset.gnt", 32'(gnt), 32'h0);
      check("reset.busy", 32'(busy), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply("rst", 4'b0010, 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0);
      apply("rst", 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      check("rst_async.gnt", 32'(gnt), 32'h0);
      check("rst_async.gnt_id", 32'(gnt_id), 32'h0);
      check("rst_async.busy", 32'(busy), 32'h0);
      check("rst_async.dp_en", 32'(dp_en), 32'h0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      apply("rst", 4'b0010, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      apply("rst", 4'b0010, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);

      do_reset();
      for (int i = 0; i < tbl.size(); i++)
         apply("rr", tbl[i].req, tbl[i].last, tbl[i].gnt, tbl[i].id, tbl[i].busy, tbl[i].dp);

      // Early last on owner 1's second beat; a last on a non-granted line is ignored.
      do_reset();
      apply("last", 4'b0110, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      apply("last", 4'b0110, 4'b0100, 4'b0010, 2'd1, 1'b1, 1'b1);
      apply("last", 4'b0110, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1);
`ifdef DP_ARB_RECOVER_EN
      apply("last", 4'b0110, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
`endif
      apply("last", 4'b0110, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1);

      // Owner 2 abandons after one beat: dp_en drops in the same cycle, grant moves to 3.
      do_reset();
      apply("abandon", 4'b1100, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      apply("abandon", 4'b1100, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1);
      apply("abandon", 4'b1000, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b0);
`ifdef DP_ARB_RECOVER_EN
      apply("abandon", 4'b1000, 4'b0000, 4'b0000, 2'd2, 1'b1, 1'b0);
`endif
      apply("abandon", 4'b1000, 4'b0000, 4'b1000, 2'd3, 1'b1, 1'b1);

      // last[0] on the HOLD-th beat: one tenure end, next owner 1 with a fresh 4-beat budget, then 2.
      do_reset();
      apply("simul", 4'b0111, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0);
      for (int b = 0; b < 3; b++)
         apply("simul", 4'b0111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b1);
      apply("simul", 4'b0111, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1);
`ifdef DP_ARB_RECOVER_EN
      apply("simul", 4'b0111, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b0);
`endif
      for (int b = 0; b < 4; b++)
         apply("simul", 4'b0111, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b1);
`ifdef DP_ARB_RECOVER_EN
      apply("simul", 4'b0111, 4'b0000, 4'b0000, 2'd1, 1'b1, 1'b0);
`endif
      apply("simul", 4'b0111, 4'b0000, 4'b0100, 2'd2, 1'b1, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/datapath_rr_arbiter.md
# datapath_rr_arbiter

Round-robin arbiter sharing one flop-feedback datapath stage (NAND input, capture flop, inverter drive chain) between NREQ requesters. Grants one requester at a time, issues the stage load enable, bounds each tenure to HOLD beats, and optionally inserts a one-cycle recovery bubble between tenures so the feedback flop settles before ownership changes.

## Interface
- NREQ, 4, number of requesters; legal range 2..16
- HOLD, 4, max load-enabled beats per grant; legal range ≥1
- tau2015_clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- req  input  NREQ  per-requester request level; held until granted or abandoned
- last  input  NREQ  per-requester end-of-burst; meaningful only in a dp_en cycle
- gnt  output  NREQ  registered one-hot grant, all-zero when no owner
- gnt_id  output  $clog2(NREQ)  registered index of current or most recent owner
- dp_en  output  1  datapath load enable = |(gnt & req), combinational
- busy  output  1  registered, high whenever state ≠ IDLE

## Operation
- States: IDLE, GRANT, RECOVER (RECOVER exists only with the macro).
- Reset values: state=IDLE, gnt=0, gnt_id=0, busy=0, ptr=0, beat=0; dp_en therefore 0.
- Winner selection: first set bit of req scanning ptr, ptr+1, … wrapping modulo NREQ.
- IDLE: any req set → GRANT; gnt=onehot(winner), gnt_id=winner, beat=0. Else stay.
- GRANT: each dp_en cycle increments beat (width $clog2(HOLD+1)).
- Tenure ends on the edge where any holds: (dp_en & last[gnt_id]); (dp_en & beat==HOLD-1); req[gnt_id]==0 (abandon, no beat counted).
- Simultaneous last and HOLD limit → one tenure end, no double advance.
- On end: ptr = (gnt_id+1) mod NREQ; gnt cleared or replaced per next state; gnt_id keeps last owner until next grant.
- Next state after end: RECOVER if macro defined; else GRANT to new winner (selected from ptr just updated) if any req set, else IDLE.
- RECOVER: exactly one cycle, gnt=0, busy=1; then GRANT to winner or IDLE.
- last on a non-granted line and last outside dp_en cycles are ignored.
- rst asserted mid-tenure: all outputs and state clear immediately, without waiting for a clock; a burst in flight is dropped.

## Timing
- req asserted before edge N with arbiter IDLE → gnt/dp_en high after edge N (1-cycle latency).
- Tenure ending at edge M: without macro the next owner's gnt is high after edge M (zero bubble); with macro gnt=0 for cycle M..M+1, next gnt after edge M+1.
- Max tenure HOLD dp_en cycles; worst-case wait per requester (NREQ-1)·(HOLD + bubble) cycles after its request is visible, where bubble is 0 without the macro and 1 with it.
- dp_en follows req combinationally within a grant; requester drop deasserts dp_en in the same cycle.
- busy rises with gnt; falls on the edge returning to IDLE.

## Configuration
- DP_ARB_RECOVER_EN defined: RECOVER state present; one dead cycle, with gnt=0 and busy=1, between every tenure and the next grant.
- Undefined: no RECOVER state; back-to-back handover on the tenure-ending edge.

## Test plan
- Reset: assert rst mid-GRANT with req=4'b0010 → gnt, gnt_id, busy, dp_en go 0 asynchronously; after release with req=4'b0010, gnt=4'b0010 one edge later.
- Round-robin: req=4'b1111 held, last never asserted, HOLD=4 → grants 0,1,2,3,0 each lasting exactly 4 dp_en cycles, ptr wraps 3→0.
- Early last: owner 1, last[1] on 2nd beat → tenure ends after 2 beats, next grant to 2 (req=4'b0110).
- Abandon: owner 2 drops req after 1 beat → dp_en falls same cycle, grant moves to 3, ptr=3.
- Simultaneous: last[0] on beat HOLD (4th) → single end, next owner 1, not 2.
- Macro: same stimulus as round-robin with DP_ARB_RECOVER_EN → one gnt=0 cycle between owners, busy stays 1 throughout.
